// File: rtl/packet_scheduler.sv
// HDMI data-island packet scheduler: picks audio, ACR, AVI, AIF, SPD or null for each packet slot.
// Optional macro PACKET_SCHEDULER_MISS_COUNT_EN builds the saturating missed-InfoFrame counter.
module packet_scheduler #(
  parameter int unsigned AUDIO_BURST = 4,
  parameter int unsigned SPD_PERIOD  = 1
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic        video_field_end,
  input  logic        packet_slot,
  input  logic        audio_sample_ready,
  input  logic        acr_tick,
  output logic [7:0]  packet_type,
  output logic        packet_valid,
  output logic        audio_sample_ack,
  output logic        infoframe_missed,
  output logic [15:0] miss_count
);

  localparam int unsigned BURST_W = 4;
  localparam int unsigned DIV_W   = 8;
  localparam int unsigned TYPE_W  = 8;

  localparam logic [TYPE_W-1:0] HB_NULL  = 8'h00;
  localparam logic [TYPE_W-1:0] HB_ACR   = 8'h01;
  localparam logic [TYPE_W-1:0] HB_AUDIO = 8'h02;
  localparam logic [TYPE_W-1:0] HB_AVI   = 8'h82;
  localparam logic [TYPE_W-1:0] HB_AIF   = 8'h84;
  localparam logic [TYPE_W-1:0] HB_SPD   = 8'h83;

  logic               acr_q, acr_d, avi_q, avi_d, aif_q, aif_d, spd_q, spd_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [TYPE_W-1:0]  type_q, type_d;
  logic               valid_q, valid_d, ack_q, ack_d, missed_q, missed_d;
  logic               burst_full;
  logic               other_pending;

  assign burst_full    = (burst_q == BURST_W'(AUDIO_BURST));
  assign other_pending = acr_q | avi_q | aif_q | spd_q;

  // Selection uses pre-update flags; sets are applied after clears so a same-cycle set wins.
  always_comb begin
    acr_d    = acr_q;
    avi_d    = avi_q;
    aif_d    = aif_q;
    spd_d    = spd_q;
    burst_d  = burst_q;
    div_d    = div_q;
    type_d   = type_q;
    valid_d  = 1'b0;
    ack_d    = 1'b0;
    missed_d = 1'b0;

    if (packet_slot) begin
      valid_d = 1'b1;
      if (audio_sample_ready && !(burst_full && other_pending)) begin
        type_d = HB_AUDIO;
        ack_d  = 1'b1;
        if (!burst_full) burst_d = burst_q + BURST_W'(1);
      end else begin
        burst_d = '0;
        if (acr_q) begin
          type_d = HB_ACR;
          acr_d  = 1'b0;
        end else if (avi_q) begin
          type_d = HB_AVI;
          avi_d  = 1'b0;
        end else if (aif_q) begin
          type_d = HB_AIF;
          aif_d  = 1'b0;
        end else if (spd_q) begin
          type_d = HB_SPD;
          spd_d  = 1'b0;
        end else begin
          type_d = HB_NULL;
        end
      end
    end

    if (acr_tick) acr_d = 1'b1;

    if (video_field_end) begin
      missed_d = avi_q | aif_q | spd_q;
      avi_d    = 1'b1;
      aif_d    = 1'b1;
      if (div_q == '0) spd_d = 1'b1;
      div_d = (div_q == DIV_W'(SPD_PERIOD - 1)) ? '0 : div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      acr_q    <= 1'b0;
      avi_q    <= 1'b0;
      aif_q    <= 1'b0;
      spd_q    <= 1'b0;
      burst_q  <= '0;
      div_q    <= '0;
      type_q   <= HB_NULL;
      valid_q  <= 1'b0;
      ack_q    <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      acr_q    <= acr_d;
      avi_q    <= avi_d;
      aif_q    <= aif_d;
      spd_q    <= spd_d;
      burst_q  <= burst_d;
      div_q    <= div_d;
      type_q   <= type_d;
      valid_q  <= valid_d;
      ack_q    <= ack_d;
      missed_q <= missed_d;
    end
  end

`ifdef PACKET_SCHEDULER_MISS_COUNT_EN
  logic [15:0] miss_q, miss_d;

  // Counter advances together with the missed pulse it counts.
  always_comb begin
    miss_d = miss_q;
    if (missed_d && (miss_q != 16'hFFFF)) miss_d = miss_q + 16'd1;
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) miss_q <= '0;
    else       miss_q <= miss_d;
  end

  assign miss_count = miss_q;
`else
  assign miss_count = '0;
`endif

  assign packet_type      = type_q;
  assign packet_valid     = valid_q;
  assign audio_sample_ack = ack_q;
  assign infoframe_missed = missed_q;

endmodule

// File: tb/tb_packet_scheduler.sv
// Directed scoreboard bench for packet_scheduler (AUDIO_BURST=4, SPD_PERIOD=2).
module tb_packet_scheduler;

  localparam int AB = 4;
  localparam int SP = 2;

  logic        clk_pixel = 1'b0;
  logic        reset, video_field_end, packet_slot, audio_sample_ready, acr_tick;
  logic [7:0]  packet_type;
  logic        packet_valid, audio_sample_ack, infoframe_missed;
  logic [15:0] miss_count;

  packet_scheduler #(.AUDIO_BURST(AB), .SPD_PERIOD(SP)) dut (
    .clk_pixel(clk_pixel), .reset(reset), .video_field_end(video_field_end),
    .packet_slot(packet_slot), .audio_sample_ready(audio_sample_ready), .acr_tick(acr_tick),
    .packet_type(packet_type), .packet_valid(packet_valid), .audio_sample_ack(audio_sample_ack),
    .infoframe_missed(infoframe_missed), .miss_count(miss_count)
  );

  always #5 clk_pixel = ~clk_pixel;

  typedef struct packed { logic [7:0] t; logic ack; } exp_t;
  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;
  logic m_acr, m_avi, m_aif, m_spd;
  int m_burst, m_div;
  logic [15:0] m_miss;
  logic [7:0] last_type;
  logic exp_miss;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_acr = 0; m_avi = 0; m_aif = 0; m_spd = 0;
    m_burst = 0; m_div = 0; m_miss = '0; last_type = 8'h00;
    sb.delete();
  endtask

  task automatic check_outputs(input string step);
    exp_t e;
    check({step, ".valid"}, 16'(packet_valid), 16'(sb.size() > 0));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({step, ".type"}, 16'(packet_type), 16'(e.t));
      check({step, ".ack"}, 16'(audio_sample_ack), 16'(e.ack));
      last_type = e.t;
    end else begin
      check({step, ".type_hold"}, 16'(packet_type), 16'(last_type));
      check({step, ".ack_idle"}, 16'(audio_sample_ack), 16'd0);
    end
    check({step, ".missed"}, 16'(infoframe_missed), 16'(exp_miss));
    check({step, ".miss_count"}, miss_count, m_miss);
  endtask

  // One clock: drive inputs, advance the reference model, then compare at the falling edge.
  task automatic cyc(input string step, input logic s, input logic f, input logic t);
    exp_t e;
    packet_slot = s; video_field_end = f; acr_tick = t;
    exp_miss = 1'b0;
    if (s) begin
      if (audio_sample_ready && !(m_burst == AB && (m_acr || m_avi || m_aif || m_spd))) begin
        e = '{8'h02, 1'b1};
        if (m_burst < AB) m_burst++;
      end else begin
        m_burst = 0;
        if (m_acr)      begin e = '{8'h01, 1'b0}; m_acr = 0; end
        else if (m_avi) begin e = '{8'h82, 1'b0}; m_avi = 0; end
        else if (m_aif) begin e = '{8'h84, 1'b0}; m_aif = 0; end
        else if (m_spd) begin e = '{8'h83, 1'b0}; m_spd = 0; end
        else            e = '{8'h00, 1'b0};
      end
      sb.push_back(e);
    end
    if (t) m_acr = 1;
    if (f) begin
      exp_miss = m_avi | m_aif | m_spd;
      m_avi = 1; m_aif = 1;
      if (m_div == 0) m_spd = 1;
      m_div = (m_div + 1) % SP;
    end
`ifdef PACKET_SCHEDULER_MISS_COUNT_EN
    if (exp_miss && m_miss != 16'hFFFF) m_miss++;
`endif
    @(posedge clk_pixel);
    @(negedge clk_pixel);
    packet_slot = 0; video_field_end = 0; acr_tick = 0;
    check_outputs(step);
  endtask

  task automatic do_reset(input string step, input logic s);
    reset = 1; packet_slot = s;
    model_clear();
    exp_miss = 1'b0;
    @(posedge clk_pixel);
    @(negedge clk_pixel);
    check_outputs(step);
    reset = 0; packet_slot = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc("idle", 0, 0, 0);
  endtask

  initial begin
    reset = 1; video_field_end = 0; packet_slot = 0; audio_sample_ready = 0; acr_tick = 0;
    @(negedge clk_pixel);
    do_reset("reset", 0);
    idle(2);

    // nothing pending: three null packets
    for (int i = 0; i < 3; i++) begin cyc("null_slot", 1, 0, 0); idle(2); end

    // first field end arms AVI, AIF and SPD; second only AVI and AIF
    cyc("fe1", 0, 1, 0); idle(1);
    for (int i = 0; i < 4; i++) begin cyc("if_slot1", 1, 0, 0); idle(1); end
    cyc("fe2", 0, 1, 0); idle(1);
    for (int i = 0; i < 3; i++) begin cyc("if_slot2", 1, 0, 0); idle(1); end

    // audio burst limit yields one slot to a pending ACR
    audio_sample_ready = 1;
    cyc("tick", 0, 0, 1); idle(1);
    for (int i = 0; i < 6; i++) begin cyc("burst_slot", 1, 0, 0); idle(1); end
    // audio alone keeps flowing past the burst count
    for (int i = 0; i < 6; i++) begin cyc("audio_only", 1, 0, 0); idle(1); end
    audio_sample_ready = 0;
    cyc("after_audio", 1, 0, 0); idle(1);

    // tick coinciding with the slot is served one slot later
    cyc("tick_slot", 1, 0, 1); idle(1);
    cyc("tick_next", 1, 0, 0); idle(1);

    // back-to-back field ends: one missed pulse
    cyc("fe3", 0, 1, 0); idle(1);
    cyc("fe4", 0, 1, 0); idle(1);
    for (int i = 0; i < 4; i++) begin cyc("drain", 1, 0, 0); idle(1); end

    // field end on a slot cycle: set wins over the clear
    cyc("fe5", 0, 1, 0); idle(1);
    cyc("fe_slot", 1, 1, 0); idle(1);
    for (int i = 0; i < 4; i++) begin cyc("drain2", 1, 0, 0); idle(1); end

    // reset together with a slot discards it
    do_reset("reset_slot", 1);
    idle(2);
    cyc("post_reset", 1, 0, 0); idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
